// File: rtl/video_timing_gen_if.sv
// Control/pixel bundle between a video timing generator and its consumer.
interface video_timing_gen_if;
  logic        en;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;
  logic [23:0] rgb;

  modport master (
    output en, pattern_sel, solid_rgb,
    input  h_cnt, v_cnt, hsync, vsync, de, frame_start, rgb
  );

  modport slave (
    input  en, pattern_sel, solid_rgb,
    output h_cnt, v_cnt, hsync, vsync, de, frame_start, rgb
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered counters, syncs, DE and pixel data.
// Define VTG_PATTERN_EN for bars/solid/target/ramp patterns; otherwise rgb is the solid colour.
module video_timing_gen #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int H_FP       = 8,
  parameter int H_SYNC     = 32,
  parameter int H_BP       = 40,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 6
) (
  input  logic              pclk,
  input  logic              rst,
  video_timing_gen_if.slave vif
);
  localparam int H_TOTAL = IMG_WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = IMG_HEIGHT + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(IMG_WIDTH);
  localparam logic [11:0] HS_BEG = 12'(IMG_WIDTH + H_FP);
  localparam logic [11:0] HS_END = 12'(IMG_WIDTH + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(IMG_HEIGHT);
  localparam logic [10:0] VS_BEG = 11'(IMG_HEIGHT + V_FP);
  localparam logic [10:0] VS_END = 11'(IMG_HEIGHT + V_FP + V_SYNC);

  logic [11:0] hc_q, hc_d;
  logic [10:0] vc_q, vc_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;
  logic [23:0] rgb_q, rgb_d;
  logic [23:0] color_q, color_d;
  logic [23:0] cur_color;
  logic [23:0] pix_rgb;
  logic        frame_top;
  logic        capture;

  assign frame_top = (hc_q == '0) && (vc_q == '0);
  assign capture   = vif.en && frame_top;
  // The first pixel of a frame already uses the freshly captured settings.
  assign cur_color = capture ? vif.solid_rgb : color_q;
  assign color_d   = cur_color;

`ifdef VTG_PATTERN_EN
  localparam int BAR_W = IMG_WIDTH / 8;
  localparam logic [11:0] TH0 = 12'(IMG_WIDTH / 2 - 16);
  localparam logic [11:0] TH1 = 12'(IMG_WIDTH / 2 + 16);
  localparam logic [10:0] TV0 = 11'(IMG_HEIGHT / 2 - 16);
  localparam logic [10:0] TV1 = 11'(IMG_HEIGHT / 2 + 16);

  logic [1:0]  pat_q, pat_d;
  logic [7:1]  bar_ge;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;
  logic        in_target;

  // Bar index = number of bar boundaries passed, which saturates at 7.
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar
      assign bar_ge[gi] = hc_q >= 12'(gi * BAR_W);
    end
  endgenerate
  assign bar_idx = 3'($countones(bar_ge));

  always_comb begin
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  assign in_target = (hc_q >= TH0) && (hc_q < TH1) && (vc_q >= TV0) && (vc_q < TV1);
  assign pat_d     = capture ? vif.pattern_sel : pat_q;

  always_comb begin
    case (pat_d)
      2'd0:    pix_rgb = bar_rgb;
      2'd1:    pix_rgb = cur_color;
      2'd2:    pix_rgb = in_target ? cur_color : 24'h808080;
      default: pix_rgb = {3{hc_q[7:0]}};
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pat_q <= '0;
    end else begin
      pat_q <= pat_d;
    end
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = ^vif.pattern_sel;
  assign pix_rgb = cur_color;
`endif

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (vif.en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 11'd1;
      end else begin
        hc_d = hc_q + 12'd1;
      end
    end
  end

  // Syncs and counters hold while disabled; DE, frame_start and pixels go quiet.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = 1'b0;
    fs_d    = 1'b0;
    rgb_d   = '0;
    if (vif.en) begin
      h_cnt_d = hc_q;
      v_cnt_d = vc_q;
      hsync_d = (hc_q >= HS_BEG) && (hc_q < HS_END);
      vsync_d = (vc_q >= VS_BEG) && (vc_q < VS_END);
      de_d    = (hc_q < H_ACT) && (vc_q < V_ACT);
      fs_d    = frame_top;
      rgb_d   = de_d ? pix_rgb : '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hc_q    <= '0;
      vc_q    <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
      color_q <= 24'hFFFFFF;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      rgb_q   <= rgb_d;
      color_q <= color_d;
    end
  end

  assign vif.h_cnt       = h_cnt_q;
  assign vif.v_cnt       = v_cnt_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.de          = de_q;
  assign vif.frame_start = fs_q;
  assign vif.rgb         = rgb_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster so several frames fit the run.
module tb_video_timing_gen;
  localparam int W   = 84;
  localparam int H   = 48;
  localparam int HFP = 8;
  localparam int HSW = 32;
  localparam int HBP = 40;
  localparam int VFP = 3;
  localparam int VSW = 4;
  localparam int VBP = 6;
  localparam int HT  = W + HFP + HSW + HBP;
  localparam int VT  = H + VFP + VSW + VBP;

  typedef struct packed {
    logic [11:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [23:0] rgb;
  } vid_t;

  logic pclk;
  logic rst;
  video_timing_gen_if vif();

  video_timing_gen #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .vif (vif)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  vid_t sb_q[$];

  // Reference model state
  int          m_hc = 0;
  int          m_vc = 0;
  logic [23:0] m_col = 24'hFFFFFF;
  vid_t        m_prev = '0;
`ifdef VTG_PATTERN_EN
  logic [1:0]  m_pat = 2'd0;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  // Observed-stream measurements
  int   last_fs  = 0;
  bit   fs_valid = 0;
  int   de_run   = 0;
  bit   de_clean = 0;
  logic prev_de  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

`ifdef VTG_PATTERN_EN
  function automatic logic [23:0] ref_pix(input logic [1:0] p, input logic [23:0] c,
                                          input int h, input int v);
    int bar;
    logic [7:0] hb;
    case (p)
      2'd0: begin
        bar = h / (W / 8);
        if (bar > 7) bar = 7;
        return BARS[bar];
      end
      2'd1: return c;
      2'd2: return (h >= W/2 - 16 && h < W/2 + 16 && v >= H/2 - 16 && v < H/2 + 16)
                   ? c : 24'h808080;
      default: begin
        hb = h[7:0];
        return {hb, hb, hb};
      end
    endcase
  endfunction
`endif

  function automatic vid_t model_step(input logic r, input logic e);
    vid_t x;
    x = m_prev;
    if (r) begin
      m_hc  = 0;
      m_vc  = 0;
      m_col = 24'hFFFFFF;
`ifdef VTG_PATTERN_EN
      m_pat = 2'd0;
`endif
      x = '0;
    end else if (!e) begin
      x.de  = 1'b0;
      x.fs  = 1'b0;
      x.rgb = '0;
    end else begin
      x.fs = (m_hc == 0 && m_vc == 0);
      if (x.fs) begin
        m_col = vif.solid_rgb;
`ifdef VTG_PATTERN_EN
        m_pat = vif.pattern_sel;
`endif
      end
      x.h  = 12'(m_hc);
      x.v  = 11'(m_vc);
      x.de = (m_hc < W) && (m_vc < H);
      x.hs = (m_hc >= W + HFP) && (m_hc < W + HFP + HSW);
      x.vs = (m_vc >= H + VFP) && (m_vc < H + VFP + VSW);
`ifdef VTG_PATTERN_EN
      x.rgb = x.de ? ref_pix(m_pat, m_col, m_hc, m_vc) : 24'h0;
`else
      x.rgb = x.de ? m_col : 24'h0;
`endif
      m_hc++;
      if (m_hc == HT) begin
        m_hc = 0;
        m_vc++;
        if (m_vc == VT) m_vc = 0;
      end
    end
    m_prev = x;
    return x;
  endfunction

  task automatic measure(input vid_t o);
    if (o.fs) begin
      if (fs_valid) check_val("fs_period", cyc - last_fs, HT * VT);
      last_fs  = cyc;
      fs_valid = 1;
    end
    if (o.de) begin
      if (!prev_de) begin
        de_run   = 0;
        de_clean = (o.h == 12'd0);
      end
      de_run++;
    end else if (prev_de && de_clean) begin
      check_val("de_run", de_run, W);
    end
    prev_de = o.de;
  endtask

  task automatic cycle(input logic r, input logic e);
    vid_t x;
    vid_t o;
    vid_t ex;
    @(negedge pclk);
    rst    = r;
    vif.en = e;
    if (r || !e) begin
      fs_valid = 0;
      de_clean = 0;
    end
    x = model_step(r, e);
    sb_q.push_back(x);
    @(posedge pclk);
    #1;
    cyc++;
    o = {vif.h_cnt, vif.v_cnt, vif.hsync, vif.vsync, vif.de, vif.frame_start, vif.rgb};
    ex = sb_q.pop_front();
    check_val("h_cnt", o.h, ex.h);
    check_val("v_cnt", o.v, ex.v);
    check_val("hsync", o.hs, ex.hs);
    check_val("vsync", o.vs, ex.vs);
    check_val("de", o.de, ex.de);
    check_val("frame_start", o.fs, ex.fs);
    check_val("rgb", o.rgb, ex.rgb);
    measure(o);
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 20000; i++) begin
      cycle(1'b0, 1'b1);
      if (m_prev.h == 12'(h) && m_prev.v == 11'(v)) return;
    end
    check_val("run_to_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst             = 1'b1;
    vif.en          = 1'b1;
    vif.pattern_sel = 2'd0;
    vif.solid_rgb   = 24'hA5C3E1;

    $display("phase reset: rst held 3 cycles");
    repeat (3) cycle(1'b1, 1'b1);

    $display("phase frame1: bars, pattern_sel->1 at v=20 must wait for next frame");
    cycle(1'b0, 1'b1);
    run_to(0, 20);
    vif.pattern_sel = 2'd1;
    vif.solid_rgb   = 24'h123456;
    run_to(0, 0);

    $display("phase frame2: solid, target setup mid-frame");
    run_to(5, 10);
    vif.pattern_sel = 2'd2;
    vif.solid_rgb   = 24'hFF0000;
    run_to(0, 0);

    $display("phase frame3: target, en=0 for 50 cycles at h=10 v=12");
    run_to(10, 12);
    repeat (50) cycle(1'b0, 1'b0);
    vif.pattern_sel = 2'd3;
    run_to(0, 0);

    $display("phase frame4: ramp, reset at v=30");
    run_to(0, 30);
    repeat (2) cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);

    $display("phase random: 800 cycles of random enable and settings");
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        vif.pattern_sel = 2'($urandom_range(0, 3));
        vif.solid_rgb   = 24'($urandom);
      end
      cycle(1'b0, $urandom_range(0, 3) != 0);
    end
    run_to(0, 0);
    repeat (3 * HT) cycle(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
